// File: rtl/apb_multi_ch_serial_regs.sv
// APB register block for NUM_CH serial engines: per-channel start/done/overrun
// tracking, RX capture, sticky W1C status and an aggregated level interrupt.
module apb_multi_ch_serial_regs #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned ADDR_W  = 12,
  parameter logic [31:0] VERSION = 32'h0002_0000
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [ADDR_W-1:0]        paddr,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [31:0]              pwdata,
  output logic [31:0]              prdata,
  output logic                     pready,
  output logic                     pslverr,
  output logic [NUM_CH-1:0]        start,
  input  logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH*DATA_W-1:0] tx_data,
  input  logic [NUM_CH*DATA_W-1:0] rx_data_in,
  output logic [NUM_CH*DIV_W-1:0]  clk_div,
  output logic [NUM_CH*DIV_W-1:0]  neg_del,
  output logic                     irq
);

  typedef enum logic {S_IDLE, S_ACK} state_t;
  typedef enum logic [2:0] {
    K_CTRL, K_STAT, K_TX, K_RX, K_DIV, K_NEG, K_RSV6, K_RSV7
  } kind_t;

  state_t            state;
  logic [NUM_CH-1:0] done, ovr, busy_d, irq_en;
  logic [DATA_W-1:0] rxd [NUM_CH];

  logic              dec_err, dec_irqen;
  logic [NUM_CH-1:0] dec_hit;
  logic [31:0]       dec_rdata;
  kind_t             dec_kind;
  logic [ADDR_W-6:0] ch_raw;

  logic              acc_write, acc_err, acc_irqen;
  kind_t             acc_kind;
  logic [NUM_CH-1:0] acc_hit;
  logic [31:0]       acc_wdata;
  logic              commit;
  logic              unused_ok;

  assign unused_ok = &{1'b0, paddr[1:0]};
  assign ch_raw    = paddr[ADDR_W-1:5] - (ADDR_W-5)'(8);
  assign dec_kind  = kind_t'(paddr[4:2]);
  assign commit    = (state == S_ACK) && acc_write && !acc_err;

  // Address decode and read mux; sampled into the access registers in IDLE.
  always_comb begin
    dec_err   = 1'b0;
    dec_irqen = 1'b0;
    dec_hit   = '0;
    dec_rdata = '0;
    if (paddr[ADDR_W-1:8] == '0) begin
      case (paddr[7:2])
        6'd0: begin dec_rdata = VERSION;             dec_err = pwrite; end
        6'd1: begin dec_rdata = {24'h0, 8'(NUM_CH)}; dec_err = pwrite; end
        6'd2: begin dec_rdata = 32'(irq_en);         dec_irqen = 1'b1; end
        6'd3: begin dec_rdata = 32'(done | ovr);     dec_err = pwrite; end
        default: dec_err = 1'b1;
      endcase
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ch_raw == (ADDR_W-5)'(c)) begin
          dec_hit[c] = 1'b1;
          case (dec_kind)
            K_CTRL:  dec_err = !pwrite;
            K_STAT:  dec_rdata = 32'({ovr[c], done[c], busy[c]});
            K_TX:    dec_rdata = 32'(tx_data[c*DATA_W +: DATA_W]);
            K_RX:    begin dec_rdata = 32'(rxd[c]); dec_err = pwrite; end
            K_DIV:   dec_rdata = 32'(clk_div[c*DIV_W +: DIV_W]);
            K_NEG:   dec_rdata = 32'(neg_del[c*DIV_W +: DIV_W]);
            default: dec_err = 1'b1;
          endcase
        end
      end
      if (dec_hit == '0) dec_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      pready    <= 1'b0;
      prdata    <= '0;
      pslverr   <= 1'b0;
      acc_write <= 1'b0;
      acc_err   <= 1'b0;
      acc_irqen <= 1'b0;
      acc_kind  <= K_CTRL;
      acc_hit   <= '0;
      acc_wdata <= '0;
      start     <= '0;
      busy_d    <= '0;
      done      <= '0;
      ovr       <= '0;
      irq_en    <= '0;
      irq       <= 1'b0;
      tx_data   <= '0;
      clk_div   <= '0;
      neg_del   <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) rxd[c] <= '0;
    end else begin
      start  <= '0;
      busy_d <= busy;
      irq    <= |(irq_en & (done | ovr));
      case (state)
        S_IDLE: begin
          if (psel && penable) begin
            state     <= S_ACK;
            pready    <= 1'b1;
            pslverr   <= dec_err;
            prdata    <= (dec_err || pwrite) ? '0 : dec_rdata;
            acc_write <= pwrite;
            acc_err   <= dec_err;
            acc_irqen <= dec_irqen;
            acc_kind  <= dec_kind;
            acc_hit   <= dec_hit;
            acc_wdata <= pwdata;
          end
        end
        S_ACK: begin
          state   <= S_IDLE;
          pready  <= 1'b0;
          prdata  <= '0;
          pslverr <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      if (commit && acc_irqen) irq_en <= acc_wdata[NUM_CH-1:0];

      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (commit && acc_hit[c]) begin
          case (acc_kind)
            K_CTRL: begin
              if (acc_wdata[0]) begin
                if (busy[c])        ovr[c]   <= 1'b1;
                else if (!start[c]) start[c] <= 1'b1;
              end
            end
            K_STAT: begin
              if (acc_wdata[1]) done[c] <= 1'b0;
              if (acc_wdata[2]) ovr[c]  <= 1'b0;
            end
            K_TX:    tx_data[c*DATA_W +: DATA_W] <= acc_wdata[DATA_W-1:0];
            K_DIV:   clk_div[c*DIV_W +: DIV_W]   <= acc_wdata[DIV_W-1:0];
            K_NEG:   neg_del[c*DIV_W +: DIV_W]   <= acc_wdata[DIV_W-1:0];
            default: ;
          endcase
        end
        // Placed after the W1C so a coincident falling edge keeps done set.
        if (busy_d[c] && !busy[c]) begin
          done[c] <= 1'b1;
          rxd[c]  <= rx_data_in[c*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_multi_ch_serial_regs.sv
// Randomised scoreboard bench for apb_multi_ch_serial_regs against a
// register-map level reference model.
module tb_apb_multi_ch_serial_regs;
  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DIV_W   = 16;
  localparam int unsigned ADDR_W  = 12;
  localparam logic [31:0] VERSION = 32'h0002_0000;

  logic                     clk = 1'b0;
  logic                     rstn;
  logic [ADDR_W-1:0]        paddr;
  logic                     psel, penable, pwrite;
  logic [31:0]              pwdata, prdata;
  logic                     pready, pslverr;
  logic [NUM_CH-1:0]        start, busy;
  logic [NUM_CH*DATA_W-1:0] tx_data, rx_data_in;
  logic [NUM_CH*DIV_W-1:0]  clk_div, neg_del;
  logic                     irq;

  apb_multi_ch_serial_regs #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIV_W(DIV_W), .ADDR_W(ADDR_W), .VERSION(VERSION)
  ) dut (
    .clk(clk), .rstn(rstn), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .start(start), .busy(busy), .tx_data(tx_data),
    .rx_data_in(rx_data_in), .clk_div(clk_div), .neg_del(neg_del), .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];

  logic [DATA_W-1:0] m_tx  [NUM_CH];
  logic [DATA_W-1:0] m_rx  [NUM_CH];
  logic [DIV_W-1:0]  m_div [NUM_CH];
  logic [DIV_W-1:0]  m_neg [NUM_CH];
  logic [NUM_CH-1:0] m_done, m_ovr, m_irqen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_tx[c] = '0; m_rx[c] = '0; m_div[c] = '0; m_neg[c] = '0;
    end
    m_done = '0; m_ovr = '0; m_irqen = '0;
  endtask

  function automatic logic model_irq();
    logic r = 1'b0;
    for (int c = 0; c < NUM_CH; c++) r = r | (m_irqen[c] & (m_done[c] | m_ovr[c]));
    return r;
  endfunction

  // Expected {pslverr, prdata} for an access, from the register map.
  function automatic logic [32:0] model_access(input logic [ADDR_W-1:0] a, input logic wr);
    int unsigned off, c, r;
    logic        err;
    logic [31:0] rd;
    off = 32'(a) & 32'hFFFF_FFFC;
    err = 1'b0;
    rd  = '0;
    if (off < 32'h100) begin
      if (off == 0)          begin rd = VERSION; err = wr; end
      else if (off == 4)     begin rd = NUM_CH;  err = wr; end
      else if (off == 8)     rd = 32'(m_irqen);
      else if (off == 'hC)   begin rd = 32'(m_done | m_ovr); err = wr; end
      else                   err = 1'b1;
    end else begin
      c = (off - 32'h100) / 32'h20;
      r = (off - 32'h100) % 32'h20;
      if (c >= NUM_CH) err = 1'b1;
      else begin
        case (r)
          0:       err = !wr;
          4:       rd = {29'h0, m_ovr[c], m_done[c], busy[c]};
          8:       rd = 32'(m_tx[c]);
          'hC:     begin rd = 32'(m_rx[c]); err = wr; end
          'h10:    rd = 32'(m_div[c]);
          'h14:    rd = 32'(m_neg[c]);
          default: err = 1'b1;
        endcase
      end
    end
    return {err, (err || wr) ? 32'h0 : rd};
  endfunction

  // Applies a legal write to the model; returns the expected start pulse mask.
  task automatic model_write(input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                             output logic [NUM_CH-1:0] st);
    int unsigned off, c, r;
    off = 32'(a) & 32'hFFFF_FFFC;
    st  = '0;
    if (off == 8) m_irqen = wd[NUM_CH-1:0];
    else if (off >= 32'h100) begin
      c = (off - 32'h100) / 32'h20;
      r = (off - 32'h100) % 32'h20;
      case (r)
        0:    if (wd[0]) begin if (busy[c]) m_ovr[c] = 1'b1; else st[c] = 1'b1; end
        4:    begin if (wd[1]) m_done[c] = 1'b0; if (wd[2]) m_ovr[c] = 1'b0; end
        8:    m_tx[c]  = wd[DATA_W-1:0];
        'h10: m_div[c] = wd[DIV_W-1:0];
        'h14: m_neg[c] = wd[DIV_W-1:0];
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    for (int c = 0; c < NUM_CH; c++) begin
      chk("tx_data", 64'(tx_data[c*DATA_W +: DATA_W]), 64'(m_tx[c]));
      chk("clk_div", 64'(clk_div[c*DIV_W +: DIV_W]), 64'(m_div[c]));
      chk("neg_del", 64'(neg_del[c*DIV_W +: DIV_W]), 64'(m_neg[c]));
    end
    chk("irq", 64'(irq), 64'(model_irq()));
    chk("start_idle", 64'(start), 64'h0);
  endtask

  task automatic apb(input logic [ADDR_W-1:0] a, input logic wr, input logic [31:0] wd);
    logic [32:0]       e;
    logic [NUM_CH-1:0] st_exp;
    int                n;
    e = model_access(a, wr);
    st_exp = '0;
    @(posedge clk); #1;
    paddr = a; pwrite = wr; pwdata = wd; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    exp_q.push_back(e);
    chk("pready_first_access_cycle", 64'(pready), 64'h0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!pready && n < 8);
    chk("pready_latency", 64'(n), 64'd1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    if (wr && !e[32]) model_write(a, wd, st_exp);
    @(posedge clk); #1;
    chk("start_pulse", 64'(start), 64'(st_exp));
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic set_busy(input logic [NUM_CH-1:0] nb, input logic [NUM_CH*DATA_W-1:0] rx);
    @(posedge clk); #1;
    for (int c = 0; c < NUM_CH; c++)
      if (busy[c] && !nb[c]) begin
        m_done[c] = 1'b1;
        m_rx[c]   = rx[c*DATA_W +: DATA_W];
      end
    busy = nb;
    rx_data_in = rx;
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (pready) begin
        if (exp_q.size() == 0) chk("unexpected_pready", 64'h1, 64'h0);
        else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("pslverr", 64'(pslverr), 64'(e[32]));
          chk("prdata", 64'(prdata), 64'(e[31:0]));
        end
      end else begin
        chk("idle_prdata_pslverr", 64'({pslverr, prdata}), 64'h0);
      end
    end
  end

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [NUM_CH*DATA_W-1:0] rx;
    logic [ADDR_W-1:0]        a;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    busy = '0; rx_data_in = '0; rstn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    chk("reset_pready", 64'(pready), 64'h0);
    chk("reset_prdata", 64'({pslverr, prdata}), 64'h0);
    rstn = 1'b1;

    apb('h000, 1'b0, '0);
    apb('h004, 1'b0, '0);
    apb('h130, 1'b1, 32'hABCD_1234);
    chk("ch1_clk_div", 64'(clk_div[31:16]), 64'h1234);
    chk("ch0_clk_div", 64'(clk_div[15:0]), 64'h0);
    apb('h130, 1'b0, '0);

    apb('h008, 1'b1, 32'h1);
    apb('h100, 1'b1, 32'h1);
    rx = '0;
    set_busy(2'b01, rx);
    repeat (10) @(posedge clk);
    rx[31:0] = 32'h5A5A_0001;
    set_busy(2'b00, rx);
    apb('h104, 1'b0, '0);
    apb('h10C, 1'b0, '0);
    chk("irq_after_done", 64'(irq), 64'h1);
    apb('h104, 1'b1, 32'h2);
    chk("irq_after_w1c", 64'(irq), 64'h0);
    apb('h104, 1'b0, '0);

    set_busy(2'b10, rx);
    apb('h120, 1'b1, 32'h1);
    apb('h124, 1'b0, '0);
    apb('h124, 1'b1, 32'h4);
    apb('h124, 1'b0, '0);
    set_busy(2'b00, rx);

    apb('h140, 1'b0, '0);
    apb('h140, 1'b1, 32'h5);
    apb('h018, 1'b0, '0);
    apb('h018, 1'b1, 32'hFFFF_FFFF);
    apb('h10C, 1'b1, 32'hFFFF_FFFF);
    apb('h100, 1'b0, '0);
    apb('h000, 1'b1, 32'h1234);
    apb('h10C, 1'b0, '0);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        for (int c = 0; c < NUM_CH; c++) rx[c*DATA_W +: DATA_W] = DATA_W'($urandom);
        set_busy(NUM_CH'($urandom), rx);
      end else begin
        case ($urandom_range(0, 4))
          0:       a = ADDR_W'($urandom_range(0, 'hFFF));
          1:       a = ADDR_W'($urandom_range(0, 3) * 4);
          default: a = ADDR_W'('h100 + $urandom_range(0, NUM_CH - 1) * 'h20 + $urandom_range(0, 5) * 4);
        endcase
        a = a | ADDR_W'($urandom_range(0, 3));
        apb(a, 1'($urandom), $urandom);
      end
    end

    // Reset asserted while a CTRL start write sits in ACK.
    set_busy(2'b00, rx);
    apb('h108, 1'b1, 32'h1234_5678);
    apb('h008, 1'b1, 32'h3);
    @(posedge clk); #1;
    paddr = 'h100; pwrite = 1'b1; pwdata = 32'h1; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    chk("pready_before_reset", 64'(pready), 64'h1);
    rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    model_reset();
    #1;
    check_outputs();
    chk("reset_pready_async", 64'(pready), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("no_start_after_reset", 64'(start), 64'h0);
    end
    apb('h108, 1'b0, '0);
    apb('h008, 1'b0, '0);
    apb('h104, 1'b0, '0);
    apb('h10C, 1'b0, '0);
    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
